// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter for the data RAM port, with optional bus lock,
// forced release after LOCK_MAX locked grants, and registered read-data return.
module ram_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (core load/store)
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic            m0_lock,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  // master 1 (DMA / loader)
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  // RAM side
  output logic            MemRead,
  output logic            MemWrite,
  output logic [DW/8-1:0] byte_enable,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   MEM_w_data,
  input  logic [DW-1:0]   MEM_r_data
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_served_q, last_served_d;  // 0: M0 served last, 1: M1
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic [7:0]    lock_cnt_inc;
  logic          sel_lock;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  // Grants are suppressed while reset is held, so no access leaks through
  // during reset even though the grant path is combinational.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            m0_gnt = last_served_q;
            m1_gnt = !last_served_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        OWN0:    m0_gnt = m0_req;
        OWN1:    m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    byte_enable = '0;
    mem_addr    = '0;
    MEM_w_data  = '0;
    sel_lock    = 1'b0;
    if (m0_gnt) begin
      MemRead     = !m0_we;
      MemWrite    = m0_we;
      byte_enable = m0_be;
      mem_addr    = m0_addr;
      MEM_w_data  = m0_wdata;
      sel_lock    = m0_lock;
    end else if (m1_gnt) begin
      MemRead     = !m1_we;
      MemWrite    = m1_we;
      byte_enable = m1_be;
      mem_addr    = m1_addr;
      MEM_w_data  = m1_wdata;
      sel_lock    = m1_lock;
    end
  end

  assign lock_cnt_inc = lock_cnt_q + 8'd1;

  // A locked grant that brings the count up to LOCK_MAX releases the bus, and
  // since last_served now names the owner, the other master wins the next tie.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    lock_cnt_d    = lock_cnt_q;
    if (m0_gnt || m1_gnt) begin
      last_served_d = m1_gnt;
      if (sel_lock && (lock_cnt_inc != LOCK_MAX_C)) begin
        state_d    = m1_gnt ? OWN1 : OWN0;
        lock_cnt_d = lock_cnt_inc;
      end else begin
        state_d    = IDLE;
        lock_cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      lock_cnt_q    <= 8'd0;
      m0_rvalid_q   <= 1'b0;
      m1_rvalid_q   <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments only.
      state_q       <= state_d;
      last_served_q <= last_served_d;
      lock_cnt_q    <= lock_cnt_d;
      m0_rvalid_q   <= m0_gnt && !m0_we;
      m1_rvalid_q   <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= MEM_r_data;
      if (m1_gnt && !m1_we) m1_rdata_q <= MEM_r_data;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: stimulus pushes expected grants and read
// returns into queues; a negedge monitor pops and compares them.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
  } req_t;

  typedef struct {
    int          cyc;
    int          master;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  req_t        p0 = '0;
  req_t        p1 = '0;
  logic [31:0] rdv = 32'h0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite;
  logic [3:0]  byte_enable;
  logic [31:0] mem_addr, MEM_w_data;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  gexp_t gq[$];
  rexp_t rq0[$];
  rexp_t rq1[$];

  ram_port_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (p0.req),
    .m0_we      (p0.we),
    .m0_be      (p0.be),
    .m0_addr    (p0.addr),
    .m0_wdata   (p0.wdata),
    .m0_lock    (p0.lock),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (p1.req),
    .m1_we      (p1.we),
    .m1_be      (p1.be),
    .m1_addr    (p1.addr),
    .m1_wdata   (p1.wdata),
    .m1_lock    (p1.lock),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .byte_enable(byte_enable),
    .mem_addr   (mem_addr),
    .MEM_w_data (MEM_w_data),
    .MEM_r_data (rdv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t rd_req(input logic [31:0] a, input logic lk);
    req_t r;
    r = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0, lock: lk};
    return r;
  endfunction

  function automatic req_t wr_req(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] b, input logic lk);
    req_t r;
    r = '{req: 1'b1, we: 1'b1, be: b, addr: a, wdata: d, lock: lk};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input int m, input req_t r);
    gexp_t e;
    e.cyc = cyc; e.master = m; e.we = r.we; e.be = r.be; e.addr = r.addr; e.wdata = r.wdata;
    gq.push_back(e);
  endtask

  task automatic exp_rd(input int m, input logic [31:0] d);
    rexp_t e;
    e.cyc = cyc + 1; e.data = d;
    if (m == 0) rq0.push_back(e);
    else        rq1.push_back(e);
  endtask

  // Monitor: grant/slave-side check and read-return check every cycle.
  gexp_t ge;
  rexp_t re;
  always @(negedge clk) begin
    check("single grant", {31'b0, m0_gnt & m1_gnt}, 32'h0);
    if (m0_gnt || m1_gnt) begin
      if (gq.size() == 0 || gq[0].cyc != cyc) begin
        check("unexpected gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
      end else begin
        ge = gq.pop_front();
        check("gnt master", {31'b0, m1_gnt}, ge.master);
        check("MemRead", {31'b0, MemRead}, {31'b0, !ge.we});
        check("MemWrite", {31'b0, MemWrite}, {31'b0, ge.we});
        check("byte_enable", {28'b0, byte_enable}, {28'b0, ge.be});
        check("mem_addr", mem_addr, ge.addr);
        check("MEM_w_data", MEM_w_data, ge.wdata);
      end
    end else begin
      check("idle slave side", {31'b0, MemRead | MemWrite | (|byte_enable) | (|mem_addr) | (|MEM_w_data)}, 32'h0);
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        ge = gq.pop_front();
        check("missing gnt", {30'b0, m0_gnt, m1_gnt}, (ge.master == 0) ? 32'h2 : 32'h1);
      end
    end

    if (m0_rvalid) begin
      if (rq0.size() == 0 || rq0[0].cyc != cyc) check("m0_rvalid unexpected", {31'b0, m0_rvalid}, 32'h0);
      else begin re = rq0.pop_front(); check("m0_rdata", m0_rdata, re.data); end
    end else if (rq0.size() > 0 && rq0[0].cyc == cyc) begin
      re = rq0.pop_front();
      check("m0_rvalid missing", {31'b0, m0_rvalid}, 32'h1);
    end

    if (m1_rvalid) begin
      if (rq1.size() == 0 || rq1[0].cyc != cyc) check("m1_rvalid unexpected", {31'b0, m1_rvalid}, 32'h0);
      else begin re = rq1.pop_front(); check("m1_rdata", m1_rdata, re.data); end
    end else if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
      re = rq1.pop_front();
      check("m1_rvalid missing", {31'b0, m1_rvalid}, 32'h1);
    end
  end

  initial begin
    // Reset held with both masters requesting: nothing may be granted.
    tick();
    tick();
    p0 = rd_req(32'h100, 1'b0);
    p1 = rd_req(32'h200, 1'b0);
    @(negedge clk);
    check("reset gnts", {30'b0, m0_gnt, m1_gnt}, 32'h0);
    check("reset rvalids", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    check("reset strobes", {30'b0, MemRead, MemWrite}, 32'h0);
    check("reset m0_rdata", m0_rdata, 32'h0);
    check("reset m1_rdata", m1_rdata, 32'h0);

    // Release: M0 wins the first tie, M1 follows.
    tick(); rst = 1'b1; rdv = 32'h1111_0000;
    exp_gnt(0, p0); exp_rd(0, rdv);
    tick(); p0 = '0; rdv = 32'h2222_0000;
    exp_gnt(1, p1); exp_rd(1, rdv);
    tick(); p1 = '0;

    // Contending writes alternate M0, M1, M0, M1.
    for (int i = 0; i < 4; i++) begin
      tick();
      p0 = wr_req(32'h20 + 32'(4 * ((i + 1) / 2)), 32'hA0A0_0000 + 32'((i + 1) / 2), 4'hF, 1'b0);
      p1 = wr_req(32'h40 + 32'(4 * (i / 2)), 32'hB1B1_0000 + 32'(i / 2), 4'h3, 1'b0);
      if (i % 2 == 0) exp_gnt(0, p0);
      else            exp_gnt(1, p1);
    end
    tick(); p0 = '0; p1 = '0;
    @(negedge clk);
    check("m1_rdata held", m1_rdata, 32'h2222_0000);

    // Uncontended M0 read.
    tick(); p0 = rd_req(32'h10, 1'b0); rdv = 32'hDEAD_BEEF;
    exp_gnt(0, p0); exp_rd(0, rdv);
    tick(); p0 = '0;

    // M1 locked reads: 4 grants, then forced release hands one grant to M0.
    for (int i = 0; i < 4; i++) begin
      tick();
      p0 = rd_req(32'h300, 1'b0);
      p1 = rd_req(32'h80 + 32'(4 * i), 1'b1);
      rdv = 32'hB000_0000 + 32'(i);
      exp_gnt(1, p1); exp_rd(1, rdv);
    end
    tick(); p1 = rd_req(32'h90, 1'b1); rdv = 32'hC000_0000;
    exp_gnt(0, p0); exp_rd(0, rdv);
    tick(); p0 = '0; p1 = rd_req(32'h90, 1'b0); rdv = 32'hC100_0000;
    exp_gnt(1, p1); exp_rd(1, rdv);
    tick(); p1 = '0;

    // M0 locks, drops req for 3 cycles: M1 stalls until M0 releases.
    tick();
    p0 = wr_req(32'h50, 32'h5050_0001, 4'hF, 1'b1);
    p1 = wr_req(32'h60, 32'h6060_0001, 4'h3, 1'b0);
    exp_gnt(0, p0);
    tick(); p0 = '0;
    tick();
    tick();
    tick(); p0 = wr_req(32'h54, 32'h5050_0002, 4'hF, 1'b0);
    exp_gnt(0, p0);
    tick(); p0 = '0;
    exp_gnt(1, p1);
    tick(); p1 = '0;

    // Reset while M1 owns the lock and its read has just been granted.
    tick(); p1 = rd_req(32'hA0, 1'b1); rdv = 32'hF00D_0000;
    exp_gnt(1, p1);
    tick(); rst = 1'b0;
    p0 = rd_req(32'h300, 1'b0);
    p1 = rd_req(32'hA4, 1'b1);
    @(negedge clk);
    check("mid-lock reset m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    check("mid-lock reset m1_rdata", m1_rdata, 32'h0);
    check("mid-lock reset m0_rdata", m0_rdata, 32'h0);
    tick(); rst = 1'b1; rdv = 32'hE0E0_0000;
    exp_gnt(0, p0); exp_rd(0, rdv);
    tick(); p0 = '0; rdv = 32'hE1E1_0000;
    exp_gnt(1, p1); exp_rd(1, rdv);
    tick(); p1 = rd_req(32'hA8, 1'b0); rdv = 32'hE2E2_0000;
    exp_gnt(1, p1); exp_rd(1, rdv);
    tick(); p1 = '0;
    tick();
    tick();
    @(negedge clk);
    #1;
    check("grant queue drained", gq.size(), 32'h0);
    check("m0 read queue drained", rq0.size(), 32'h0);
    check("m1 read queue drained", rq1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
